// File: rtl/axis_digest_tx.sv
// AXI4-Stream master that serializes a full-width digest into 16-bit beats,
// least-significant word first, with a one-entry pending buffer for back-to-back hashes.
module axis_digest_tx #(
  parameter int DIGEST_W = 256
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_valid,
  output logic                digest_ready,
  output logic [15:0]         M_TDATA,
  output logic                M_TVALID,
  input  logic                M_TREADY,
  output logic                M_TLAST,
  output logic [3:0]          M_TUSER
);

  localparam int BEATS    = (DIGEST_W + 15) / 16;
  localparam int ACT_W    = BEATS * 16;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NIB_MOD  = (DIGEST_W / 4) % 4;
  localparam int LAST_NIB = (NIB_MOD == 0) ? 4 : NIB_MOD;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [15:0]      LAST_MASK = 16'((32'd1 << (4 * LAST_NIB)) - 32'd1);
  localparam logic [3:0]       LAST_USER = 4'(LAST_NIB);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ACT_W-1:0]    r_active;
  logic [CNT_W-1:0]    r_beatCnt;
  logic [DIGEST_W-1:0] r_pendData;
  logic                r_pendFull;

  logic w_accept;
  logic w_beat;
  logic w_lastBeat;
  logic w_loadIn;
  logic w_loadPend;
  logic w_shift;
  logic w_writePend;

  assign digest_ready = ~r_pendFull;
  assign w_accept     = digest_valid & ~r_pendFull;
  assign w_lastBeat   = (r_beatCnt == LAST_CNT);
  assign w_beat       = (r_state == SEND) & M_TREADY;

  always_comb begin
    w_stateNext = r_state;
    w_loadIn    = 1'b0;
    w_loadPend  = 1'b0;
    w_shift     = 1'b0;
    w_writePend = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_loadIn    = 1'b1;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        if (w_beat && w_lastBeat) begin
          // A pending digest has priority; ready is low then, so no accept competes.
          if (r_pendFull) begin
            w_loadPend = 1'b1;
          end else if (w_accept) begin
            w_loadIn = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_shift     = w_beat;
          w_writePend = w_accept;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_active  <= '0;
      r_beatCnt <= '0;
    end else if (w_loadIn) begin
      r_active  <= ACT_W'(digest);
      r_beatCnt <= '0;
    end else if (w_loadPend) begin
      r_active  <= ACT_W'(r_pendData);
      r_beatCnt <= '0;
    end else if (w_shift) begin
      r_active  <= r_active >> 16;
      r_beatCnt <= r_beatCnt + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pendData <= '0;
      r_pendFull <= 1'b0;
    end else if (w_writePend) begin
      r_pendData <= digest;
      r_pendFull <= 1'b1;
    end else if (w_loadPend) begin
      r_pendFull <= 1'b0;
    end
  end

  // Outputs depend only on registered state, so they stay put during a stall.
  assign M_TVALID = (r_state == SEND);
  assign M_TLAST  = (r_state == SEND) & w_lastBeat;
  assign M_TDATA  = (r_state == SEND) ? (r_active[15:0] & (M_TLAST ? LAST_MASK : 16'hFFFF)) : 16'h0000;
  assign M_TUSER  = (r_state == SEND) ? (M_TLAST ? LAST_USER : 4'd4) : 4'd0;

endmodule

// File: tb/tb_axis_digest_tx.sv
// Scoreboard bench for axis_digest_tx: a 256-bit instance for the main scenarios
// and a 20-bit instance for the partial final word.
module tb_axis_digest_tx;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [3:0]  user;
  } beat_t;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic [15:0]  M_TDATA;
  logic         M_TVALID;
  logic         M_TREADY;
  logic         M_TLAST;
  logic [3:0]   M_TUSER;

  logic [19:0]  p_digest;
  logic         p_digestValid;
  logic         p_digestReady;
  logic [15:0]  p_tdata;
  logic         p_tvalid;
  logic         p_tready;
  logic         p_tlast;
  logic [3:0]   p_tuser;

  int checks = 0;
  int errors = 0;

  beat_t sbq[$];
  beat_t exp;

  logic        obsValid;
  logic        obsBeat;
  logic        obsAcc;
  logic [15:0] obsData;
  logic        obsLast;
  logic [3:0]  obsUser;

  axis_digest_tx #(.DIGEST_W(256)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .M_TLAST(M_TLAST), .M_TUSER(M_TUSER)
  );

  axis_digest_tx #(.DIGEST_W(20)) dutPartial (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .digest(p_digest), .digest_valid(p_digestValid), .digest_ready(p_digestReady),
    .M_TDATA(p_tdata), .M_TVALID(p_tvalid), .M_TREADY(p_tready),
    .M_TLAST(p_tlast), .M_TUSER(p_tuser)
  );

  always #5 ACLK = ~ACLK;

  // Drive one cycle from a negedge, record what the next posedge will see, and
  // push the expected beats of any digest accepted on that edge.
  task automatic tick(input logic rdy, input logic vld, input logic [255:0] d);
    M_TREADY     = rdy;
    digest_valid = vld;
    digest       = d;
    #1;
    obsValid = M_TVALID;
    obsBeat  = M_TVALID & rdy;
    obsData  = M_TDATA;
    obsLast  = M_TLAST;
    obsUser  = M_TUSER;
    obsAcc   = vld & digest_ready;
    if (obsAcc) begin
      for (int k = 0; k < 16; k++) begin
        sbq.push_back('{data: d[16*k +: 16], last: (k == 15), user: 4'd4});
      end
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic logic [255:0] randDigest();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    ARESETN = 1'b0;
    digest = '0; digest_valid = 1'b0; M_TREADY = 1'b0;
    p_digest = '0; p_digestValid = 1'b0; p_tready = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if (M_TVALID !== 1'b0 || M_TLAST !== 1'b0 || M_TUSER !== 4'd0 || M_TDATA !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b last=%b user=%0d data=%h expected 0 0 0 0000", M_TVALID, M_TLAST, M_TUSER, M_TDATA);
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if (digest_ready !== 1'b1 || p_digestReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b/%b expected 1/1", digest_ready, p_digestReady);
    end
  endtask

  task automatic test_single();
    logic [255:0] d;
    int beats = 0;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
    tick(1'b1, 1'b1, d);
    checks++;
    if (obsAcc !== 1'b1) begin
      errors++;
      $display("FAIL single_accept got %b expected 1", obsAcc);
    end
    for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
      tick(1'b1, 1'b0, '0);
      if (c == 0) begin
        checks++;
        if (obsBeat !== 1'b1) begin
          errors++;
          $display("FAIL single_latency got valid=%b expected 1", obsValid);
        end
      end
      if (obsBeat) begin
        exp = sbq.pop_front();
        beats++;
        checks++;
        if (obsData !== exp.data || obsLast !== exp.last || obsUser !== exp.user) begin
          errors++;
          $display("FAIL single_beat%0d got %h/%b/%0d expected %h/%b/%0d", beats - 1, obsData, obsLast, obsUser, exp.data, exp.last, exp.user);
        end
      end
    end
    checks++;
    if (beats !== 16 || sbq.size() != 0) begin
      errors++;
      $display("FAIL single_count got %0d beats expected 16", beats);
    end
  endtask

  task automatic test_backpressure();
    logic        rdy;
    logic        prevStall = 1'b0;
    logic [15:0] prevData = '0;
    logic        prevLast = 1'b0;
    logic [3:0]  prevUser = '0;
    int beats = 0;
    tick(1'b0, 1'b1, randDigest());
    for (int c = 0; c < 300 && sbq.size() > 0; c++) begin
      rdy = 1'($urandom_range(0, 1));
      tick(rdy, 1'b0, '0);
      if (prevStall) begin
        checks++;
        if (obsValid !== 1'b1 || obsData !== prevData || obsLast !== prevLast || obsUser !== prevUser) begin
          errors++;
          $display("FAIL bp_stable got %b/%h/%b/%0d expected 1/%h/%b/%0d", obsValid, obsData, obsLast, obsUser, prevData, prevLast, prevUser);
        end
      end
      if (obsBeat) begin
        exp = sbq.pop_front();
        beats++;
        checks++;
        if (obsData !== exp.data || obsLast !== exp.last || obsUser !== exp.user) begin
          errors++;
          $display("FAIL bp_beat%0d got %h/%b/%0d expected %h/%b/%0d", beats - 1, obsData, obsLast, obsUser, exp.data, exp.last, exp.user);
        end
      end
      prevStall = obsValid & ~rdy;
      prevData  = obsData;
      prevLast  = obsLast;
      prevUser  = obsUser;
    end
    tick(1'b1, 1'b0, '0);
    checks++;
    if (beats !== 16 || obsValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count got %0d beats trailing valid=%b expected 16 and 0", beats, obsValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ds [3];
    int next = 0, beats = 0, gaps = 0, beatsAtThird = -1;
    for (int i = 0; i < 3; i++) ds[i] = randDigest();
    for (int c = 0; c < 120 && (next < 3 || sbq.size() > 0); c++) begin
      tick(1'b1, (next < 3), (next < 3) ? ds[next] : 256'h0);
      if (obsAcc) begin
        if (next == 2) beatsAtThird = beats;
        next++;
      end
      if (obsBeat) begin
        exp = sbq.pop_front();
        beats++;
        checks++;
        if (obsData !== exp.data || obsLast !== exp.last || obsUser !== exp.user) begin
          errors++;
          $display("FAIL b2b_beat%0d got %h/%b/%0d expected %h/%b/%0d", beats - 1, obsData, obsLast, obsUser, exp.data, exp.last, exp.user);
        end
      end else if (beats > 0 && beats < 48) begin
        gaps++;
      end
    end
    checks++;
    if (beatsAtThird !== 16) begin
      errors++;
      $display("FAIL b2b_third_stall got accept after %0d beats expected 16", beatsAtThird);
    end
    checks++;
    if (beats !== 48 || gaps !== 0) begin
      errors++;
      $display("FAIL b2b_stream got beats=%0d gaps=%0d expected 48 and 0", beats, gaps);
    end
  endtask

  task automatic test_same_cycle();
    logic [255:0] d0, d1;
    logic vld;
    logic sent = 1'b0;
    int beats = 0;
    d0 = randDigest();
    d1 = randDigest();
    tick(1'b1, 1'b1, d0);
    for (int c = 0; c < 80 && sbq.size() > 0; c++) begin
      vld = M_TLAST & ~sent;
      tick(1'b1, vld, d1);
      if (obsBeat) begin
        exp = sbq.pop_front();
        beats++;
        checks++;
        if (obsData !== exp.data || obsLast !== exp.last || obsUser !== exp.user) begin
          errors++;
          $display("FAIL same_beat%0d got %h/%b/%0d expected %h/%b/%0d", beats - 1, obsData, obsLast, obsUser, exp.data, exp.last, exp.user);
        end
      end
      if (vld) begin
        sent = 1'b1;
        checks++;
        if (obsAcc !== 1'b1 || M_TVALID !== 1'b1 || digest_ready !== 1'b1 || M_TDATA !== d1[15:0]) begin
          errors++;
          $display("FAIL same_handoff got acc=%b valid=%b ready=%b data=%h expected 1 1 1 %h", obsAcc, M_TVALID, digest_ready, M_TDATA, d1[15:0]);
        end
      end
    end
    checks++;
    if (beats !== 32 || sent !== 1'b1) begin
      errors++;
      $display("FAIL same_count got beats=%0d sent=%b expected 32 and 1", beats, sent);
    end
  endtask

  task automatic test_partial();
    beat_t pq[$];
    int beats = 0;
    p_digest      = 20'h9BEEF;
    p_digestValid = 1'b1;
    p_tready      = 1'b1;
    #1;
    if (p_digestReady) begin
      pq.push_back('{data: 16'hBEEF, last: 1'b0, user: 4'd4});
      pq.push_back('{data: 16'h0009, last: 1'b1, user: 4'd1});
    end
    @(posedge ACLK);
    @(negedge ACLK);
    p_digestValid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (p_tvalid) begin
        beats++;
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL partial_extra got beat %h expected none", p_tdata);
        end else begin
          exp = pq.pop_front();
          if (p_tdata !== exp.data || p_tlast !== exp.last || p_tuser !== exp.user) begin
            errors++;
            $display("FAIL partial_beat%0d got %h/%b/%0d expected %h/%b/%0d", beats - 1, p_tdata, p_tlast, p_tuser, exp.data, exp.last, exp.user);
          end
        end
      end
      @(posedge ACLK);
      @(negedge ACLK);
    end
    checks++;
    if (beats !== 2) begin
      errors++;
      $display("FAIL partial_count got %0d expected 2", beats);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d2;
    int beats = 0;
    tick(1'b1, 1'b1, randDigest());
    tick(1'b1, 1'b1, randDigest());
    if (obsBeat) beats++;
    for (int c = 0; c < 20 && beats < 6; c++) begin
      tick(1'b1, 1'b0, '0);
      if (obsBeat) beats++;
    end
    #2;
    ARESETN = 1'b0;
    #1;
    checks++;
    if (M_TVALID !== 1'b0 || M_TDATA !== 16'h0) begin
      errors++;
      $display("FAIL midrst_drop got valid=%b data=%h expected 0 0000", M_TVALID, M_TDATA);
    end
    sbq.delete();
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if (digest_ready !== 1'b1 || M_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release got ready=%b valid=%b expected 1 0", digest_ready, M_TVALID);
    end
    d2 = randDigest();
    beats = 0;
    tick(1'b1, 1'b1, d2);
    for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
      tick(1'b1, 1'b0, '0);
      if (obsBeat) begin
        exp = sbq.pop_front();
        beats++;
        checks++;
        if (obsData !== exp.data || obsLast !== exp.last || obsUser !== exp.user) begin
          errors++;
          $display("FAIL midrst_beat%0d got %h/%b/%0d expected %h/%b/%0d", beats - 1, obsData, obsLast, obsUser, exp.data, exp.last, exp.user);
        end
      end
    end
    tick(1'b1, 1'b0, '0);
    checks++;
    if (beats !== 16 || obsValid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_count got beats=%0d trailing valid=%b expected 16 and 0", beats, obsValid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_same_cycle();
    test_partial();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_digest_tx.md
# axis_digest_tx

AXI4-Stream master that serializes a completed Keccak/SHA-3 digest into 16-bit beats, the output-side counterpart of the 16-bit input padder on the message stream. It accepts a full-width digest on a valid/ready handshake and emits it least-significant word first. TLAST marks the final beat, and TUSER carries the valid-nibble count, using the same nibble granularity as the input side. A one-entry pending buffer lets the core hand over the next digest while the current one is still draining, so back-to-back hashes stream without bubbles.

## Interface

Parameters:
- `DIGEST_W`, default 256. Digest width in bits; must be a multiple of 4 and in the range 16..1600.
- `BEATS`, derived as ceil(`DIGEST_W`/16). Beats per digest; not user-overridable.
- `LAST_NIB`, derived as (`DIGEST_W`/4) mod 4, with 0 mapped to 4. Valid nibbles in the final beat.

Ports (name, direction, width, meaning):
- `ACLK` in 1: the single clock; all logic on its rising edge.
- `ARESETN` in 1: asynchronous, active-low reset. Assertion is asynchronous; release is expected synchronous to `ACLK`.
- `digest` in `DIGEST_W`: digest from the core; bit 0 is the first output bit.
- `digest_valid` in 1: `digest` is valid.
- `digest_ready` out 1: block can accept a digest. Equals NOT pending_full.
- `M_TDATA` out 16: output word.
- `M_TVALID` out 1: beat valid.
- `M_TREADY` in 1: downstream accepts the beat.
- `M_TLAST` out 1: final beat of a digest.
- `M_TUSER` out 4: valid nibbles in the beat. Value is 4 on every non-final beat and `LAST_NIB` on the final beat.

## Operation

- Accept event: `digest_valid` AND `digest_ready` at a rising edge.
- Beat event: `M_TVALID` AND `M_TREADY` at a rising edge.
- Storage:
  - Active shift register, `BEATS`×16 bits.
  - Beat counter, clog2(`BEATS`) bits.
  - Pending register, `DIGEST_W` bits, plus a pending_full flag.
- Beat k carries `digest[16k+15:16k]`. On the final beat, nibbles at or above `LAST_NIB` are driven to 0.
- FSM states are IDLE (no active digest) and SEND (active digest draining).
- In IDLE:
  - Accept loads the digest directly into the active register, clears the counter, and moves to SEND.
  - `M_TVALID` is 0.
- In SEND:
  - `M_TVALID` is 1.
  - A non-final beat event shifts the active register right by 16 and increments the counter.
  - A final beat event (counter = `BEATS`-1) ends the current digest. The next state depends on what is waiting:
    - If pending_full is set, pending moves to active, the counter clears, pending_full clears, and the FSM stays in SEND.
    - Else, if an accept occurs in the same cycle, the incoming digest loads directly into active and the FSM stays in SEND.
    - Else the FSM goes to IDLE.
  - Any other accept in SEND writes pending and sets pending_full.
- When pending_full and a final beat event coincide, `digest_ready` is still 0 that cycle. No accept is possible then, so no overwrite can occur.
- `M_TLAST` = SEND AND counter = `BEATS`-1.
- `M_TUSER` = `LAST_NIB` when `M_TLAST` is 1, else 4.
- AXIS stability: while `M_TVALID`=1 and `M_TREADY`=0, `M_TDATA`, `M_TLAST` and `M_TUSER` hold constant. `M_TVALID` never drops without a beat event.
- A digest held on the input while `digest_ready`=0 is not sampled.

## Timing

- Reset values:
  - IDLE, counter 0, pending_full 0.
  - `M_TVALID`=0, `M_TLAST`=0, `M_TUSER`=0, `M_TDATA`=0.
  - `digest_ready`=1 from the first cycle after release.
- Reset asserted mid-digest immediately drops `M_TVALID` and discards both the active and pending digests. No partial resume occurs.
- Latency: an accept in IDLE at edge N gives `M_TVALID`=1 with beat 0 after edge N.
- Throughput: with `M_TREADY` held high, one beat per cycle. `BEATS` cycles per digest, with zero idle cycles between consecutive digests when the next one is already pending or accepted on the final beat.
- `digest_ready` is a registered-state function with no combinational path from `M_TREADY`.
- Capacity: at most 2 digests in the block (one active, one pending). A third is stalled until the active digest's final beat.

## Test plan

- Single digest, `DIGEST_W`=256, `digest`=0x…1F1E…0100 counting pattern, `M_TREADY`=1: expect 16 beats, 0x0100 first, 0x1F1E last. `M_TLAST` only on beat 15. `M_TUSER`=4 on every beat.
- Backpressure: `M_TREADY` toggled 1,0,0,1 pseudo-randomly: expect `M_TDATA`, `M_TLAST` and `M_TUSER` held stable during stalls, no beat lost or duplicated, and a 16-beat total.
- Back-to-back: three digests offered with `digest_valid` held high and `M_TREADY`=1: expect the third stalled (`digest_ready`=0) until the first's final beat, and 48 contiguous beats with no `M_TVALID` gap.
- Same-cycle accept: second digest offered exactly on the first's final beat with pending empty: expect beat 0 of the second on the next cycle and pending_full still 0.
- Partial word, `DIGEST_W`=20: expect 2 beats. Beat 1 `M_TDATA`=0x000X (X=`digest[19:16]`), `M_TLAST`=1, `M_TUSER`=1.
- Reset mid-digest after beat 5 with a pending digest: expect `M_TVALID`=0 immediately and `digest_ready`=1 after release. The next accepted digest starts at beat 0 with no stale data.
